// File: rtl/dvs_ravens_pkg.sv
// Shared constants and types for the DVS AER receive path.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package dvs_ravens_pkg;

  localparam int TIMESTAMP_US_BITS = 32;

  // Channel-id field width; a single camera still carries a 1-bit id.
  function automatic int ch_bits(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  // Event word: {chan, ts, x[8:0], y[9:0], pol}
  function automatic int mc_event_bits(input int num_ch);
    return ch_bits(num_ch) + TIMESTAMP_US_BITS + 9 + 10 + 1;
  endfunction

  localparam int MC_EVENT_BITS = mc_event_bits(4);

  typedef enum logic [1:0] {
    CH_IDLE    = 2'd0,
    CH_CAPTURE = 2'd1,
    CH_PEND    = 2'd2,
    CH_ACK     = 2'd3
  } ch_state_e;

endpackage

// File: rtl/dvs_aer_mux_queue_if.sv
// AER camera handshake bundle plus the event-stream output of the queue.
// Latency: n/a (wiring only).
// Backpressure: evt_ready from the consumer; ack per channel towards the cameras.
interface dvs_aer_mux_queue_if #(
  parameter int NUM_CH = 4
);
  import dvs_ravens_pkg::*;

  localparam int EVT_W = mc_event_bits(NUM_CH);

  logic [NUM_CH*10-1:0] aer;
  logic [NUM_CH-1:0]    xsel;
  logic [NUM_CH-1:0]    req;
  logic [NUM_CH-1:0]    ack;
  logic [EVT_W-1:0]     evt_data;
  logic                 evt_valid;
  logic                 evt_ready;

  modport slave (
    input  aer, xsel, req, evt_ready,
    output ack, evt_data, evt_valid
  );

  modport master (
    output aer, xsel, req, evt_ready,
    input  ack, evt_data, evt_valid
  );

endinterface

// File: rtl/dvs_aer_channel_rx.sv
// One AER channel: req synchroniser, 4-phase handshake FSM, y/x word capture.
// Latency: req rise -> ack after 3 edges (y word), >=4 edges (x word, waits for i_done).
// Backpressure: an x word sits in PEND with ack low until the top pushes or drops it.
module dvs_aer_channel_rx
  import dvs_ravens_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_req,
  input  logic [9:0]                   i_aer,
  input  logic                         i_xsel,
  input  logic [TIMESTAMP_US_BITS-1:0] i_time_us,
  input  logic                         i_done,
  output logic                         o_ack,
  output logic                         o_pend,
  output logic [8:0]                   o_x,
  output logic [9:0]                   o_y,
  output logic                         o_pol,
  output logic [TIMESTAMP_US_BITS-1:0] o_ts
);

  logic [1:0]                   r_sync;
  ch_state_e                    r_state;
  ch_state_e                    w_state_nxt;
  logic                         r_ack;
  logic [8:0]                   r_x;
  logic [9:0]                   r_y;
  logic                         r_pol;
  logic [TIMESTAMP_US_BITS-1:0] r_ts;

  // Two-flop synchroniser for the camera's asynchronous request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 2'b00;
    else        r_sync <= {r_sync[0], i_req};
  end

  // State register; ack is registered from the next state so it tracks ACK exactly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CH_IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= (w_state_nxt == CH_ACK);
    end
  end

  // Handshake next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      CH_IDLE:    if (r_sync[1]) w_state_nxt = CH_CAPTURE;
      CH_CAPTURE: w_state_nxt = i_xsel ? CH_PEND : CH_ACK;
      CH_PEND:    if (i_done) w_state_nxt = CH_ACK;
      CH_ACK:     if (!r_sync[1]) w_state_nxt = CH_IDLE;
      default:    w_state_nxt = CH_IDLE;
    endcase
  end

  // Sample the address word only in CAPTURE, where it is stable under req
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_pol <= 1'b0;
      r_ts  <= '0;
    end else if (r_state == CH_CAPTURE) begin
      if (i_xsel) begin
        r_x   <= i_aer[9:1];
        r_pol <= i_aer[0];
        r_ts  <= i_time_us;
      end else begin
        r_y   <= i_aer;
      end
    end
  end

  assign o_ack  = r_ack;
  assign o_pend = (r_state == CH_PEND);
  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_pol  = r_pol;
  assign o_ts   = r_ts;

endmodule

// File: rtl/dvs_aer_mux_queue.sv
// Merges NUM_CH AER cameras into one timestamped event stream via round-robin + FWFT queue.
// Latency: x word req rise -> event on evt_valid after edge 4 when uncontended and not full.
// Backpressure: full queue holds PEND channels (ack low), or drops and counts when DROP_ON_FULL=1.
module dvs_aer_mux_queue
  import dvs_ravens_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  dvs_aer_mux_queue_if.slave           bus,
  input  logic [TIMESTAMP_US_BITS-1:0] time_us,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [15:0]                  drop_count
);

  localparam int CH_BITS = ch_bits(NUM_CH);
  localparam int EVT_W   = mc_event_bits(NUM_CH);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = AW + 1;

  logic [NUM_CH-1:0]            w_pend;
  logic [NUM_CH-1:0]            w_done;
  logic [NUM_CH-1:0]            w_ack;
  logic [8:0]                   w_x   [NUM_CH];
  logic [9:0]                   w_y   [NUM_CH];
  logic                         w_pol [NUM_CH];
  logic [TIMESTAMP_US_BITS-1:0] w_ts  [NUM_CH];

  logic [CH_BITS-1:0] r_rr_ptr;
  logic [CH_BITS-1:0] w_gnt_idx;
  logic [CH_BITS-1:0] w_ptr_nxt;
  logic               w_gnt_vld;

  logic [EVT_W-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [15:0]        r_drop_cnt;
  logic               w_full;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [EVT_W-1:0]   w_evt;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    dvs_aer_channel_rx u_rx (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (bus.req[c]),
      .i_aer     (bus.aer[c*10 +: 10]),
      .i_xsel    (bus.xsel[c]),
      .i_time_us (time_us),
      .i_done    (w_done[c]),
      .o_ack     (w_ack[c]),
      .o_pend    (w_pend[c]),
      .o_x       (w_x[c]),
      .o_y       (w_y[c]),
      .o_pol     (w_pol[c]),
      .o_ts      (w_ts[c])
    );
  end

  // Channel index 'off' places after 'base', wrapping at NUM_CH
  function automatic logic [CH_BITS-1:0] rr_idx(input logic [CH_BITS-1:0] base, input int off);
    int sum;
    sum = (int'(base) + off) % NUM_CH;
    return sum[CH_BITS-1:0];
  endfunction

  // Round-robin pick: scan from the far end so the pointer's own channel wins last
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (w_pend[rr_idx(r_rr_ptr, k)]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = rr_idx(r_rr_ptr, k);
      end
    end
  end

  assign w_ptr_nxt = rr_idx(w_gnt_idx, 1);
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop     = bus.evt_ready && (r_count != '0);
  assign w_push    = w_gnt_vld && (!w_full || w_pop);
  assign w_drop    = (DROP_ON_FULL != 0) && w_gnt_vld && w_full && !w_pop;
  assign w_done    = (w_push || w_drop) ? (NUM_CH'(1) << w_gnt_idx) : '0;
  assign w_evt     = {w_gnt_idx, w_ts[w_gnt_idx], w_x[w_gnt_idx], w_y[w_gnt_idx], w_pol[w_gnt_idx]};

  // Queue storage carries no reset; occupancy alone says what is valid
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_evt;
  end

  // Pointers, occupancy, arbiter pointer and saturating drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rr_ptr   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_push || w_drop) r_rr_ptr <= w_ptr_nxt;
      if (w_drop && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.ack       = w_ack;
  assign bus.evt_data  = r_mem[r_rd_ptr];
  assign bus.evt_valid = (r_count != '0);
  assign fifo_count    = r_count;
  assign drop_count    = r_drop_cnt;

endmodule

// File: tb/tb_dvs_aer_mux_queue.sv
// Directed bench: two 4-channel, 4-deep instances (backpressure and drop variants).
// Latency: inputs driven and outputs sampled on the falling clock edge.
// Backpressure: evt_ready driven per instance; handshakes wait with bounded loops.
module tb_dvs_aer_mux_queue;
  import dvs_ravens_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_a, rst_n_b;
  logic [39:0] aer_d;
  logic [3:0]  xsel_d, req_d;
  logic [31:0] ts_d;
  logic        rdy_a, rdy_b, sel_b;
  logic [2:0]  cnt_a, cnt_b;
  logic [15:0] drop_a, drop_b;
  int          n_cmp = 0;
  int          n_err = 0;
  int          y_exp [4];

  dvs_aer_mux_queue_if #(.NUM_CH(4)) if_a ();
  dvs_aer_mux_queue_if #(.NUM_CH(4)) if_b ();

  assign if_a.aer = aer_d;  assign if_a.xsel = xsel_d;  assign if_a.req = req_d;  assign if_a.evt_ready = rdy_a;
  assign if_b.aer = aer_d;  assign if_b.xsel = xsel_d;  assign if_b.req = req_d;  assign if_b.evt_ready = rdy_b;

  dvs_aer_mux_queue #(.NUM_CH(4), .FIFO_DEPTH(4), .DROP_ON_FULL(0)) u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .bus(if_a), .time_us(ts_d), .fifo_count(cnt_a), .drop_count(drop_a));
  dvs_aer_mux_queue #(.NUM_CH(4), .FIFO_DEPTH(4), .DROP_ON_FULL(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .bus(if_b), .time_us(ts_d), .fifo_count(cnt_b), .drop_count(drop_b));

  logic [3:0]               w_ack;
  logic                     w_vld;
  logic [MC_EVENT_BITS-1:0] w_dat;
  logic [2:0]               w_cnt;
  logic [15:0]              w_drop;
  assign w_ack  = sel_b ? if_b.ack       : if_a.ack;
  assign w_vld  = sel_b ? if_b.evt_valid : if_a.evt_valid;
  assign w_dat  = sel_b ? if_b.evt_data  : if_a.evt_data;
  assign w_cnt  = sel_b ? cnt_b          : cnt_a;
  assign w_drop = sel_b ? drop_b         : drop_a;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk_evt(input int ch, input int ts, input int x, input int y, input int pol);
    return {10'd0, ch[1:0], ts[31:0], x[8:0], y[9:0], pol[0]};
  endfunction

  function automatic logic [9:0] xword(input int x, input int pol);
    return {x[8:0], pol[0]};
  endfunction

  task automatic drive_ch(input int c, input logic [9:0] w, input logic xs);
    aer_d[c*10 +: 10] = w;
    xsel_d[c]         = xs;
    req_d[c]          = 1'b1;
  endtask

  task automatic wait_ack(input int c, input logic lvl, input string tag);
    for (int i = 0; i < 20 && w_ack[c] !== lvl; i++) @(negedge clk);
    check_val(tag, 64'(w_ack[c]), 64'(lvl));
  endtask

  task automatic release_all(input string tag);
    req_d = '0;
    for (int i = 0; i < 20 && w_ack !== 4'b0000; i++) @(negedge clk);
    check_val(tag, 64'(w_ack), 64'(0));
  endtask

  task automatic pop_chk(input string tag, input logic [63:0] exp);
    check_val({tag, "_vld"}, 64'(w_vld), 64'(1));
    check_val(tag, 64'(w_dat), exp);
    if (sel_b) rdy_b = 1'b1; else rdy_a = 1'b1;
    @(negedge clk);
    rdy_a = 1'b0;
    rdy_b = 1'b0;
  endtask

  // All four channels raise x words together; grants must walk from 'start'
  task automatic burst(input int start, input int ts, input string tag);
    logic [3:0] exp_ack;
    exp_ack = 4'b0000;
    ts_d    = ts;
    for (int c = 0; c < 4; c++) drive_ch(c, xword(20 + c, c % 2), 1'b1);
    repeat (4) @(negedge clk);
    check_val({tag, "_pend"}, 64'(w_ack), 64'(0));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp_ack[(start + k) % 4] = 1'b1;
      check_val($sformatf("%s_gnt%0d", tag, k), 64'(w_ack), 64'(exp_ack));
    end
    release_all({tag, "_rel"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aer_d = '0; xsel_d = '0; req_d = '0; ts_d = '0;
    rdy_a = 1'b0; rdy_b = 1'b0; sel_b = 1'b0;
    rst_n_a = 1'b0; rst_n_b = 1'b0;
    for (int i = 0; i < 4; i++) y_exp[i] = 0;
    repeat (3) @(negedge clk);

    // Reset state of both instances
    check_val("rst_ack_a",  64'(if_a.ack),       64'(0));
    check_val("rst_vld_a",  64'(if_a.evt_valid), 64'(0));
    check_val("rst_cnt_a",  64'(cnt_a),          64'(0));
    check_val("rst_drop_a", 64'(drop_a),         64'(0));
    check_val("rst_vld_b",  64'(if_b.evt_valid), 64'(0));
    check_val("rst_drop_b", 64'(drop_b),         64'(0));
    rst_n_a = 1'b1;
    @(negedge clk);

    // Simultaneous burst from a fresh pointer: grants 0,1,2,3, queue full
    burst(0, 300, "rr0");
    check_val("rr0_cnt", 64'(w_cnt), 64'(4));

    // Two more x words while full: both held with ack low
    ts_d = 400;
    drive_ch(0, xword(50, 1), 1'b1);
    drive_ch(1, xword(51, 1), 1'b1);
    repeat (8) @(negedge clk);
    check_val("bp_hold_ack", 64'(w_ack), 64'(0));
    check_val("bp_hold_cnt", 64'(w_cnt), 64'(4));
    pop_chk("bp_pop0", mk_evt(0, 300, 20, 0, 0));
    check_val("pushpop_cnt0", 64'(w_cnt), 64'(4));
    check_val("pushpop_ack0", 64'(w_ack), 64'(4'b0001));
    pop_chk("bp_pop1", mk_evt(1, 300, 21, 0, 1));
    check_val("pushpop_cnt1", 64'(w_cnt), 64'(4));
    check_val("pushpop_ack1", 64'(w_ack), 64'(4'b0011));
    pop_chk("bp_pop2", mk_evt(2, 300, 22, 0, 0));
    pop_chk("bp_pop3", mk_evt(3, 300, 23, 0, 1));
    pop_chk("bp_pop4", mk_evt(0, 400, 50, 0, 1));
    pop_chk("bp_pop5", mk_evt(1, 400, 51, 0, 1));
    check_val("bp_empty_vld", 64'(w_vld), 64'(0));
    check_val("bp_empty_cnt", 64'(w_cnt), 64'(0));
    release_all("bp_rel");

    // Last grant was channel 1, so the next burst starts at channel 2
    burst(2, 500, "rr2");
    pop_chk("rr2_pop0", mk_evt(2, 500, 22, 0, 0));
    pop_chk("rr2_pop1", mk_evt(3, 500, 23, 0, 1));
    pop_chk("rr2_pop2", mk_evt(0, 500, 20, 0, 0));
    pop_chk("rr2_pop3", mk_evt(1, 500, 21, 0, 1));

    // Single channel: y word then x word, with edge-exact ack timing
    drive_ch(0, 10'd37, 1'b0);
    repeat (3) @(negedge clk);
    check_val("y_ack_e2", 64'(w_ack[0]), 64'(0));
    @(negedge clk);
    check_val("y_ack_e3", 64'(w_ack[0]), 64'(1));
    y_exp[0] = 37;
    req_d[0] = 1'b0;
    wait_ack(0, 1'b0, "y_rel");
    ts_d = 100;
    drive_ch(0, 10'b0000011011, 1'b1);
    repeat (4) @(negedge clk);
    check_val("x_ack_e3", 64'(w_ack[0]), 64'(0));
    check_val("x_vld_e3", 64'(w_vld),    64'(0));
    @(negedge clk);
    check_val("x_ack_e4", 64'(w_ack[0]), 64'(1));
    check_val("x_vld_e4", 64'(w_vld),    64'(1));
    check_val("x_evt",    64'(w_dat),    mk_evt(0, 100, 13, y_exp[0], 1));
    check_val("x_cnt",    64'(w_cnt),    64'(1));
    req_d[0] = 1'b0;
    wait_ack(0, 1'b0, "x_rel");

    // Reset with channel 1 in ACK and channel 2 in PEND
    ts_d = 700;
    drive_ch(1, 10'd55, 1'b0);
    drive_ch(2, xword(77, 0), 1'b1);
    repeat (4) @(negedge clk);
    check_val("pre_rst_ack", 64'(w_ack), 64'(4'b0010));
    check_val("pre_rst_vld", 64'(w_vld), 64'(1));
    rst_n_a = 1'b0;
    #1;
    check_val("mid_rst_ack", 64'(w_ack), 64'(0));
    check_val("mid_rst_vld", 64'(w_vld), 64'(0));
    check_val("mid_rst_cnt", 64'(w_cnt), 64'(0));
    req_d = '0;
    repeat (2) @(negedge clk);
    rst_n_a = 1'b1;
    for (int i = 0; i < 4; i++) y_exp[i] = 0;
    @(negedge clk);
    ts_d = 800;
    drive_ch(1, xword(88, 1), 1'b1);
    repeat (5) @(negedge clk);
    check_val("post_rst_ack", 64'(w_ack), 64'(4'b0010));
    pop_chk("post_rst_evt", mk_evt(1, 800, 88, y_exp[1], 1));
    release_all("post_rst_rel");

    // Drop variant: same six-event stimulus, all handshakes complete
    sel_b   = 1'b1;
    rst_n_b = 1'b1;
    @(negedge clk);
    burst(0, 900, "drop_rr");
    ts_d = 950;
    drive_ch(0, xword(50, 1), 1'b1);
    drive_ch(1, xword(51, 1), 1'b1);
    repeat (6) @(negedge clk);
    check_val("drop_ack",  64'(w_ack),  64'(4'b0011));
    check_val("drop_cnt",  64'(w_drop), 64'(2));
    check_val("drop_fifo", 64'(w_cnt),  64'(4));
    release_all("drop_rel");
    for (int c = 0; c < 4; c++)
      pop_chk($sformatf("drop_pop%0d", c), mk_evt(c, 900, 20 + c, 0, c % 2));
    check_val("drop_cnt_end",  64'(w_drop), 64'(2));
    check_val("drop_fifo_end", 64'(w_cnt),  64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
